// File: rtl/axis_variable_slew.sv
// -----------------------------------------------------------------------------
// axis_variable_slew
//
// Slew-rate limiter for a signed setpoint carried on AXI4-Stream.
//
// A new target arrives on the slave stream. An internal "current" value then
// walks toward that target. It moves by at most cfg_step every cfg_div + 1
// clocks. Each new current value goes out as one beat on the master stream.
// Downstream backpressure pauses the walk, so no intermediate value is dropped.
//
// Parameters
//   AXIS_TDATA_WIDTH  setpoint/output width, two's-complement signed
//   STEP_WIDTH        cfg_step width, unsigned, <= AXIS_TDATA_WIDTH
//   DIV_WIDTH         cfg_div width and the width of the divider counter
//
// Ports
//   aclk            single clock for all logic
//   aresetn         asynchronous, active-low reset
//   cfg_step        maximum change per update (0 = jump straight to target)
//   cfg_div         update interval minus one, in clocks
//   s_axis_tdata    new target
//   s_axis_tvalid   target valid
//   s_axis_tready   high whenever out of reset (registered)
//   m_axis_tdata    current value (registered)
//   m_axis_tvalid   new current value pending
//   m_axis_tready   downstream accept
//   busy            high while a ramp is in progress
// -----------------------------------------------------------------------------
module axis_variable_slew #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int STEP_WIDTH       = 16,
  parameter int DIV_WIDTH        = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [STEP_WIDTH-1:0]       cfg_step,
  input  logic [DIV_WIDTH-1:0]        cfg_div,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        busy
);

  localparam int W  = AXIS_TDATA_WIDTH;
  // One extra bit so that target - current never overflows, even between the
  // most positive and most negative setpoints.
  localparam int DW = AXIS_TDATA_WIDTH + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               r_state;
  logic [W-1:0]         r_target;
  logic [W-1:0]         r_current;
  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 r_out_valid;
  logic                 r_ready;

  state_t               w_state_next;
  logic [W-1:0]         w_target_next;
  logic [W-1:0]         w_current_next;
  logic [DIV_WIDTH-1:0] w_cnt_next;
  logic                 w_out_valid_next;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic                 w_accept;
  logic                 w_new_differs;
  logic                 w_div_done;
  logic                 w_tick;
  logic [DW-1:0]        w_diff;
  logic                 w_diff_neg;
  logic [DW-1:0]        w_diff_mag;
  logic [DW-1:0]        w_step_ext;
  logic                 w_within_step;
  logic [W-1:0]         w_step_w;
  logic [W-1:0]         w_stepped;

  assign w_accept      = s_axis_tvalid & r_ready;
  assign w_new_differs = (s_axis_tdata != r_current);

  // ">=" rather than "==" keeps the divider safe when cfg_div shrinks mid-ramp.
  // Without it, cnt could already be past the new limit and would then never
  // match it.
  assign w_div_done = (r_cnt >= cfg_div);

  // An update happens only when there is still distance to cover, the
  // interval has expired, and the output register is free or being drained
  // on this same edge.
  assign w_tick = (r_state == ST_RAMP) && (r_current != r_target) &&
                  w_div_done && (!r_out_valid || m_axis_tready);

  // Signed difference at W+1 bits, computed from sign-extended operands.
  assign w_diff     = {r_target[W-1], r_target} - {r_current[W-1], r_current};
  assign w_diff_neg = w_diff[DW-1];
  assign w_diff_mag = w_diff_neg ? (DW'(0) - w_diff) : w_diff;

  assign w_step_ext    = DW'(cfg_step);
  assign w_within_step = (cfg_step == '0) || (w_diff_mag <= w_step_ext);

  // Here the remaining distance is larger than the step. A single step
  // therefore lands strictly between current and target, so the result
  // cannot wrap at W bits.
  assign w_step_w  = W'(cfg_step);
  assign w_stepped = w_diff_neg ? (r_current - w_step_w) : (r_current + w_step_w);

  // ---------------------------------------------------------------------------
  // Next-state / next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_target_next    = r_target;
    w_current_next   = r_current;
    w_cnt_next       = r_cnt;
    w_out_valid_next = r_out_valid;

    // The last accepted target always wins, whatever the state.
    if (w_accept) begin
      w_target_next = s_axis_tdata;
    end

    // A beat is consumed here. A tick below may re-arm valid on the same
    // edge, which gives back-to-back beats.
    if (r_out_valid && m_axis_tready) begin
      w_out_valid_next = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_new_differs) begin
          w_state_next = ST_RAMP;
          w_cnt_next   = '0;
        end
      end

      ST_RAMP: begin
        if (w_tick) begin
          // The tick uses r_target. A target accepted on this same edge
          // takes effect from the next cycle.
          w_cnt_next       = '0;
          w_out_valid_next = 1'b1;
          w_current_next   = w_within_step ? r_target : w_stepped;
        end else begin
          if (!w_div_done) begin
            w_cnt_next = r_cnt + DIV_WIDTH'(1);
          end
          // The ramp is finished once current has met target. A fresh,
          // different target arriving on this edge keeps the ramp alive,
          // so that target is not dropped.
          if ((r_current == r_target) && !(w_accept && w_new_differs)) begin
            w_state_next = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_target    <= '0;
      r_current   <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_target    <= w_target_next;
      r_current   <= w_current_next;
      r_cnt       <= w_cnt_next;
      r_out_valid <= w_out_valid_next;
      r_ready     <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_axis_tready = r_ready;
  assign m_axis_tdata  = r_current;
  assign m_axis_tvalid = r_out_valid;
  assign busy          = (r_state == ST_RAMP);

endmodule

// File: tb/tb_axis_variable_slew.sv
// -----------------------------------------------------------------------------
// tb_axis_variable_slew
//
// Self-checking bench for axis_variable_slew. Expected beat sequences come
// from a plain arithmetic model: repeatedly move toward the target by at most
// the step size. A negedge monitor collects every beat accepted downstream.
// -----------------------------------------------------------------------------
module tb_axis_variable_slew;

  logic        aclk;
  logic        aresetn;
  logic [15:0] cfg_step;
  logic [15:0] cfg_div;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        busy;

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  longint model_cur = 0;

  longint got_q[$];
  int     stamp_q[$];
  longint exp_q[$];

  axis_variable_slew #(
    .AXIS_TDATA_WIDTH(32),
    .STEP_WIDTH(16),
    .DIV_WIDTH(16)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .cfg_step(cfg_step),
    .cfg_div(cfg_div),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .busy(busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Inputs only change 2ns after a rising edge. A handshake seen here
  // therefore completes on the next rising edge, numbered cyc + 1.
  always @(negedge aclk) begin
    if (aresetn && m_axis_tvalid && m_axis_tready) begin
      got_q.push_back(longint'($signed(m_axis_tdata)));
      stamp_q.push_back(cyc + 1);
    end
  end

  // Reference model: from start, move toward tgt by at most step each update.
  // A step of 0 jumps straight to the target. Appends to exp_q.
  function automatic void build_exp(input longint start, input longint tgt, input longint step);
    longint c;
    longint d;
    longint ad;
    c = start;
    while (c != tgt) begin
      d  = tgt - c;
      ad = (d < 0) ? -d : d;
      if (step == 0 || ad <= step) c = tgt;
      else if (d > 0)              c = c + step;
      else                         c = c - step;
      exp_q.push_back(c);
    end
  endfunction

  task automatic sync();
    @(posedge aclk);
    #2;
  endtask

  task automatic send_target(input longint v);
    s_axis_tdata  = 32'(v);
    s_axis_tvalid = 1'b1;
    sync();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while ((busy || m_axis_tvalid) && n < budget);
    total++;
    if (busy || m_axis_tvalid) begin
      bad++;
      $display("FAIL wait_idle: busy=%0b tvalid=%0b still high after %0d cycles, required 0", busy, m_axis_tvalid, budget);
    end
    sync();
  endtask

  task automatic goto_value(input longint v);
    cfg_step      = 16'd0;
    cfg_div       = 16'd0;
    m_axis_tready = 1'b1;
    send_target(v);
    wait_idle(50);
    got_q.delete();
    stamp_q.delete();
    model_cur = v;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    aresetn       = 1'b0;
    cfg_step      = 16'd0;
    cfg_div       = 16'd0;
    s_axis_tdata  = 32'd0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    total++;
    if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got=%0b exp=0", m_axis_tvalid); end
    total++;
    if (m_axis_tdata !== 32'd0) begin bad++; $display("FAIL reset_tdata: got=%0h exp=0", m_axis_tdata); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%0b exp=0", busy); end
    total++;
    if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL reset_tready: got=%0b exp=0", s_axis_tready); end
    sync();
    aresetn = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    total++;
    if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL release_tready: got=%0b exp=1", s_axis_tready); end
    sync();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_basic_ramp();
    cfg_step = 16'd10;
    cfg_div  = 16'd0;
    m_axis_tready = 1'b1;
    got_q.delete(); stamp_q.delete(); exp_q.delete();
    build_exp(model_cur, 35, 10);
    send_target(35);
    wait_idle(100);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL basic_count: got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_beat%0d: got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
      end
      for (int i = 1; i < stamp_q.size(); i++) begin
        total++;
        if (stamp_q[i] - stamp_q[i-1] != 1) begin bad++; $display("FAIL basic_spacing%0d: got=%0d exp=1", i, stamp_q[i] - stamp_q[i-1]); end
      end
    end
    model_cur = 35;
    // The same target again: no ramp and no beat.
    got_q.delete(); stamp_q.delete();
    send_target(35);
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      total++;
      if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
        bad++; $display("FAIL same_target_idle: busy=%0b tvalid=%0b exp 0/0", busy, m_axis_tvalid);
      end
    end
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL same_target_beats: got=%0d exp=0", got_q.size()); end
    sync();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reverse_and_extreme();
    cfg_step = 16'd16;
    cfg_div  = 16'd0;
    got_q.delete(); stamp_q.delete(); exp_q.delete();
    build_exp(model_cur, -5, 16);
    send_target(-5);
    wait_idle(100);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL reverse_count: got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL reverse_beat%0d: got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
      end
    end
    // Most positive value down toward the most negative value.
    goto_value(64'sh7FFF_FFFF);
    m_axis_tready = 1'b0;
    cfg_step      = 16'h4000;
    exp_q.delete();
    build_exp(64'sh7FFF_FFFF, -64'sh8000_0000, 64'sh4000);
    send_target(-64'sh8000_0000);
    @(posedge aclk);
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      total++;
      if (m_axis_tvalid !== 1'b1 || longint'($signed(m_axis_tdata)) !== exp_q[0]) begin
        bad++; $display("FAIL extreme_first: valid=%0b data=%0h exp valid=1 data=%0h", m_axis_tvalid, m_axis_tdata, 32'(exp_q[0]));
      end
    end
    sync();
    // Stop the ramp where it stands, then drain the single pending beat.
    send_target(exp_q[0]);
    m_axis_tready = 1'b1;
    wait_idle(50);
    total++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL extreme_beats: count=%0d exp count=1 value=%0h", got_q.size(), 32'(exp_q[0]));
    end
    model_cur = exp_q[0];
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    goto_value(0);
    cfg_step      = 16'd1;
    cfg_div       = 16'd0;
    m_axis_tready = 1'b0;
    exp_q.delete();
    build_exp(0, 3, 1);
    send_target(3);
    @(posedge aclk);
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      total++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd1) begin
        bad++; $display("FAIL stall_hold%0d: valid=%0b data=%0d exp valid=1 data=1", k, m_axis_tvalid, m_axis_tdata);
      end
      @(posedge aclk);
    end
    #2;
    m_axis_tready = 1'b1;
    wait_idle(50);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL stall_count: got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_beat%0d: got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
      end
      for (int i = 1; i < stamp_q.size(); i++) begin
        total++;
        if (stamp_q[i] - stamp_q[i-1] != 1) begin bad++; $display("FAIL stall_b2b%0d: got=%0d exp=1", i, stamp_q[i] - stamp_q[i-1]); end
      end
    end
    model_cur = 3;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_divider();
    logic exp_v;
    goto_value(0);
    cfg_step      = 16'd1;
    cfg_div       = 16'd3;
    m_axis_tready = 1'b1;
    send_target(2);                       // accepted on edge E0
    for (int k = 1; k <= 9; k++) begin
      @(posedge aclk);                    // edge E0 + k
      @(negedge aclk);
      exp_v = (k == 4 || k == 8);
      total++;
      if (m_axis_tvalid !== exp_v) begin
        bad++; $display("FAIL div_valid_E0+%0d: got=%0b exp=%0b", k, m_axis_tvalid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (m_axis_tdata !== 32'(k / 4)) begin
          bad++; $display("FAIL div_data_E0+%0d: got=%0d exp=%0d", k, m_axis_tdata, k / 4);
        end
      end
    end
    sync();
    wait_idle(50);
    // Shrink the interval while the counter is at 2.
    goto_value(0);
    cfg_step = 16'd1;
    cfg_div  = 16'd3;
    send_target(5);                       // E0
    @(posedge aclk);                      // E0+1: cnt 1
    @(posedge aclk);                      // E0+2: cnt 2
    #2;
    cfg_div = 16'd0;
    @(negedge aclk);
    total++;
    if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL div_shrink_before: got=%0b exp=0", m_axis_tvalid); end
    @(posedge aclk);                      // E0+3: tick
    @(negedge aclk);
    total++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'd1) begin
      bad++; $display("FAIL div_shrink_tick: valid=%0b data=%0d exp valid=1 data=1", m_axis_tvalid, m_axis_tdata);
    end
    sync();
    wait_idle(50);
    model_cur = 5;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_jump_and_retarget();
    int n;
    goto_value(0);
    cfg_step = 16'd0;
    exp_q.delete();
    build_exp(0, 1000, 0);
    send_target(1000);
    wait_idle(50);
    total++;
    if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL jump: count=%0d exp count=1 value=%0d", got_q.size(), exp_q[0]);
    end
    goto_value(0);
    cfg_step = 16'd10;
    cfg_div  = 16'd3;
    send_target(100);
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!(m_axis_tvalid && m_axis_tdata == 32'd30) && n < 100);
    total++;
    if (!(m_axis_tvalid && m_axis_tdata == 32'd30)) begin
      bad++; $display("FAIL retarget_reach30: data=%0d exp=30 within 100 cycles", m_axis_tdata);
    end
    sync();
    send_target(5);
    wait_idle(100);
    exp_q.delete();
    exp_q.push_back(10); exp_q.push_back(20); exp_q.push_back(30);
    build_exp(30, 5, 10);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL retarget_count: got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL retarget_beat%0d: got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
      end
    end
    model_cur = 5;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    longint tgt;
    longint step;
    logic   prev_stall;
    logic [31:0] prev_data;
    int     n;
    for (int it = 0; it < 8; it++) begin
      step = ($urandom_range(0, 3) == 0) ? 0 : longint'($urandom_range(500, 3000));
      tgt  = model_cur + longint'($urandom_range(0, 40000)) - 20000;
      cfg_step = 16'(step);
      cfg_div  = 16'($urandom_range(0, 3));
      m_axis_tready = 1'b1;
      got_q.delete(); stamp_q.delete(); exp_q.delete();
      build_exp(model_cur, tgt, step);
      send_target(tgt);
      prev_stall = 1'b0;
      prev_data  = '0;
      n = 0;
      do begin
        m_axis_tready = ($urandom_range(0, 2) != 0);
        @(negedge aclk);
        if (prev_stall) begin
          total++;
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data) begin
            bad++; $display("FAIL rand_stable it%0d: valid=%0b data=%0h exp valid=1 data=%0h", it, m_axis_tvalid, m_axis_tdata, prev_data);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        n++;
        sync();
      end while ((busy || m_axis_tvalid) && n < 2000);
      total++;
      if (busy || m_axis_tvalid) begin bad++; $display("FAIL rand_timeout it%0d: still busy after %0d cycles, required idle", it, n); end
      m_axis_tready = 1'b1;
      total++;
      if (got_q.size() != exp_q.size()) begin
        bad++; $display("FAIL rand_count it%0d: got=%0d exp=%0d", it, got_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          total++;
          if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_beat it%0d.%0d: got=%0d exp=%0d", it, i, got_q[i], exp_q[i]); end
        end
      end
      $display("random ramp %0d: step=%0d div=%0d target=%0d beats=%0d", it, step, cfg_div, tgt, got_q.size());
      model_cur = tgt;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midramp();
    goto_value(0);
    cfg_step = 16'd1;
    cfg_div  = 16'd0;
    send_target(1000);
    repeat (3) sync();
    aresetn = 1'b0;
    #1;
    total++;
    if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL midreset_tvalid: got=%0b exp=0", m_axis_tvalid); end
    total++;
    if (m_axis_tdata !== 32'd0) begin bad++; $display("FAIL midreset_tdata: got=%0h exp=0", m_axis_tdata); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy: got=%0b exp=0", busy); end
    total++;
    if (s_axis_tready !== 1'b0) begin bad++; $display("FAIL midreset_tready: got=%0b exp=0", s_axis_tready); end
    sync();
    aresetn = 1'b1;
    got_q.delete(); stamp_q.delete();
    repeat (6) sync();
    @(negedge aclk);
    total++;
    if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || got_q.size() != 0) begin
      bad++; $display("FAIL midreset_target_lost: busy=%0b tvalid=%0b beats=%0d exp 0/0/0", busy, m_axis_tvalid, got_q.size());
    end
    total++;
    if (s_axis_tready !== 1'b1) begin bad++; $display("FAIL midreset_release_tready: got=%0b exp=1", s_axis_tready); end
    sync();
    model_cur = 0;
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_basic_ramp();
    test_reverse_and_extreme();
    test_backpressure();
    test_divider();
    test_jump_and_retarget();
    test_random();
    test_reset_midramp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
